// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared types and constants for the icache linefill responder
package toy_pack;

    localparam int ICACHE_REQ_ADDR_WIDTH   = 32;
    localparam int ICACHE_REQ_TXNID_WIDTH  = 4;
    localparam int ICACHE_REQ_OPCODE_WIDTH = 3;
    localparam int MSHR_ENTRY_INDEX_WIDTH  = 2;

    localparam int LFR_BEATS  = 4;
    localparam int LFR_BEAT_W = 128;

    typedef logic [ICACHE_REQ_ADDR_WIDTH-1:0] req_addr_t;

    typedef struct packed {
        req_addr_t                           addr;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0]   txnid;
        logic [ICACHE_REQ_OPCODE_WIDTH-1:0]  opcode;
    } pc_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } lfr_state_e;

    typedef struct packed {
        pc_req_t                            req;
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  entry_id;
    } lfr_q_entry_t;

    // Zero the low n bits of an address.
    function automatic req_addr_t lfr_clear_low(input req_addr_t addr, input int unsigned n);
        return addr & ~((req_addr_t'(1) << n) - req_addr_t'(1));
    endfunction

endpackage

// File: rtl/icache_lfr_req_fifo.sv
// rtl/icache_lfr_req_fifo.sv - synchronous request queue of lfr_q_entry_t
module icache_lfr_req_fifo
    import toy_pack::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  lfr_q_entry_t  push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output lfr_q_entry_t  head
);

    localparam int AW = $clog2(DEPTH);

    lfr_q_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/icache_linefill_responder.sv
// rtl/icache_linefill_responder.sv - icache miss linefill responder (ICACHE_LFR_CRITICAL_WORD_FIRST_EN selects critical-word-first)
module icache_linefill_responder
    import toy_pack::*;
#(
    parameter int REQ_DEPTH   = 4,
    parameter int ENTRY_IDX_W = MSHR_ENTRY_INDEX_WIDTH,
    parameter int BEAT_W      = LFR_BEAT_W,
    parameter int BEATS       = LFR_BEATS,
    parameter int OFFSET_W    = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 txreq_vld,
    output logic                                 txreq_rdy,
    input  pc_req_t                              txreq_pld,
    input  logic [ENTRY_IDX_W-1:0]               txreq_entry_id,
    output logic                                 mem_req_vld,
    input  logic                                 mem_req_rdy,
    output req_addr_t                            mem_req_addr,
    input  logic                                 mem_rsp_vld,
    output logic                                 mem_rsp_rdy,
    input  logic [BEAT_W-1:0]                    mem_rsp_data,
    output logic                                 rxdat_vld,
    input  logic                                 rxdat_rdy,
    output logic [BEAT_W-1:0]                    rxdat_data,
    output logic [$clog2(BEATS)-1:0]             rxdat_beat,
    output logic [ENTRY_IDX_W-1:0]               rxdat_entry_idx,
    output logic [ICACHE_REQ_TXNID_WIDTH-1:0]    rxdat_txnid,
    output logic                                 linefill_done,
    output logic [ENTRY_IDX_W:0]                 linefill_ack_entry_idx,
    output logic                                 txrsp_vld,
    output logic [ICACHE_REQ_OPCODE_WIDTH-1:0]   txrsp_opcode,
    output logic                                 busy
);

    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int CNT_W      = $clog2(REQ_DEPTH) + 1;
`ifdef ICACHE_LFR_CRITICAL_WORD_FIRST_EN
    localparam int CLR_W      = OFFSET_W - BEAT_IDX_W;
`else
    localparam int CLR_W      = OFFSET_W;
`endif

    lfr_state_e             state_q;
    lfr_state_e             state_d;
    logic [BEAT_IDX_W-1:0]  beat_cnt_q;
    logic                   cnt_clr;
    logic                   cnt_inc;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       count;
    lfr_q_entry_t           head;
    lfr_q_entry_t           push_entry;
    logic [BEAT_IDX_W-1:0]  start_beat;
    logic                   beat_hs;
    logic                   last_beat;

    assign push_entry = '{req: txreq_pld, entry_id: txreq_entry_id};

    // Ready follows the registered full flag only, so a full queue never bypasses.
    assign txreq_rdy = !rst_n && !full;
    assign push      = txreq_vld && txreq_rdy;

`ifdef ICACHE_LFR_CRITICAL_WORD_FIRST_EN
    assign start_beat = head.req.addr[OFFSET_W-1 -: BEAT_IDX_W];
`else
    assign start_beat = '0;
`endif

    assign beat_hs   = mem_rsp_vld && rxdat_rdy;
    assign last_beat = beat_hs && (beat_cnt_q == BEAT_IDX_W'(BEATS - 1));

    icache_lfr_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .CW    (CNT_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    // Next-state and outputs; everything is held at zero while reset is asserted.
    always_comb begin
        state_d                = state_q;
        cnt_clr                = 1'b0;
        cnt_inc                = 1'b0;
        pop                    = 1'b0;
        mem_req_vld            = 1'b0;
        mem_req_addr           = '0;
        mem_rsp_rdy            = 1'b0;
        rxdat_vld              = 1'b0;
        rxdat_data             = '0;
        rxdat_beat             = '0;
        rxdat_entry_idx        = '0;
        rxdat_txnid            = '0;
        linefill_done          = 1'b0;
        linefill_ack_entry_idx = '0;
        txrsp_vld              = 1'b0;
        txrsp_opcode           = '0;
        busy                   = 1'b0;
        if (!rst_n) begin
            busy = (state_q != IDLE) || !empty;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_d = MREQ;
                    end
                end
                MREQ: begin
                    mem_req_vld  = 1'b1;
                    mem_req_addr = lfr_clear_low(head.req.addr, CLR_W);
                    if (mem_req_rdy) begin
                        cnt_clr = 1'b1;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    rxdat_vld       = mem_rsp_vld;
                    mem_rsp_rdy     = rxdat_rdy;
                    rxdat_data      = mem_rsp_data;
                    rxdat_beat      = start_beat + beat_cnt_q;
                    rxdat_entry_idx = head.entry_id;
                    rxdat_txnid     = head.req.txnid;
                    cnt_inc         = beat_hs;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    linefill_done          = 1'b1;
                    linefill_ack_entry_idx = {1'b0, head.entry_id};
                    txrsp_vld              = 1'b1;
                    txrsp_opcode           = head.req.opcode;
                    pop                    = 1'b1;
                    // A same-cycle push keeps the queue occupied after the pop.
                    state_d = ((count > CNT_W'(1)) || push) ? MREQ : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and beat counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                beat_cnt_q <= '0;
            end else if (cnt_inc) begin
                beat_cnt_q <= beat_cnt_q + BEAT_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_linefill_responder.sv
// tb/tb_icache_linefill_responder.sv - randomized self-checking bench for icache_linefill_responder
module tb_icache_linefill_responder;
    import toy_pack::*;

    localparam int REQ_DEPTH = 4;
    localparam int EW        = MSHR_ENTRY_INDEX_WIDTH;
    localparam int BEAT_W    = 128;
    localparam int BEATS     = 4;
    localparam int OFFSET_W  = 6;
    localparam int TW        = ICACHE_REQ_TXNID_WIDTH;
    localparam int OW        = ICACHE_REQ_OPCODE_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  txreq_vld;
    logic                  txreq_rdy;
    pc_req_t               txreq_pld;
    logic [EW-1:0]         txreq_entry_id;
    logic                  mem_req_vld;
    logic                  mem_req_rdy;
    req_addr_t             mem_req_addr;
    logic                  mem_rsp_vld;
    logic                  mem_rsp_rdy;
    logic [BEAT_W-1:0]     mem_rsp_data;
    logic                  rxdat_vld;
    logic                  rxdat_rdy;
    logic [BEAT_W-1:0]     rxdat_data;
    logic [1:0]            rxdat_beat;
    logic [EW-1:0]         rxdat_entry_idx;
    logic [TW-1:0]         rxdat_txnid;
    logic                  linefill_done;
    logic [EW:0]           linefill_ack_entry_idx;
    logic                  txrsp_vld;
    logic [OW-1:0]         txrsp_opcode;
    logic                  busy;

    always #5 clk = ~clk;

    icache_linefill_responder #(
        .REQ_DEPTH   (REQ_DEPTH),
        .ENTRY_IDX_W (EW),
        .BEAT_W      (BEAT_W),
        .BEATS       (BEATS),
        .OFFSET_W    (OFFSET_W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .txreq_vld              (txreq_vld),
        .txreq_rdy              (txreq_rdy),
        .txreq_pld              (txreq_pld),
        .txreq_entry_id         (txreq_entry_id),
        .mem_req_vld            (mem_req_vld),
        .mem_req_rdy            (mem_req_rdy),
        .mem_req_addr           (mem_req_addr),
        .mem_rsp_vld            (mem_rsp_vld),
        .mem_rsp_rdy            (mem_rsp_rdy),
        .mem_rsp_data           (mem_rsp_data),
        .rxdat_vld              (rxdat_vld),
        .rxdat_rdy              (rxdat_rdy),
        .rxdat_data             (rxdat_data),
        .rxdat_beat             (rxdat_beat),
        .rxdat_entry_idx        (rxdat_entry_idx),
        .rxdat_txnid            (rxdat_txnid),
        .linefill_done          (linefill_done),
        .linefill_ack_entry_idx (linefill_ack_entry_idx),
        .txrsp_vld              (txrsp_vld),
        .txrsp_opcode           (txrsp_opcode),
        .busy                   (busy)
    );

    typedef struct {
        logic [31:0]   addr;
        logic [TW-1:0] txnid;
        logic [OW-1:0] opcode;
        logic [EW-1:0] entry;
    } mreq_t;

    // Reference model state: accepted requests in arrival order, head is in flight.
    mreq_t       mq[$];
    int          nbeats = 0;
    int          beat_log[$];
    int          done_log[$];
    logic [31:0] addr_log[$];
    int          cyc = 0;
    int          last_beat_cyc = 0;
    logic        prev_done = 1'b0;
    bit          expect_mreq = 1'b0;
    int          mreq_cnt = 0;
    int          beat_cnt_seen = 0;
    int          flush_cnt = 0;

    bit          mem_hold;
    bit          mem_fast;
    int          rx_mode;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_line(input logic [31:0] a);
`ifdef ICACHE_LFR_CRITICAL_WORD_FIRST_EN
        return a & 32'hFFFF_FFF0;
`else
        return a & 32'hFFFF_FFC0;
`endif
    endfunction

    function automatic int exp_beat(input logic [31:0] a, input int n);
`ifdef ICACHE_LFR_CRITICAL_WORD_FIRST_EN
        return (int'(a[5:4]) + n) % BEATS;
`else
        return n;
`endif
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        mreq_t m;
        cyc++;
        if (rst_n) begin
            check_eq("rst_no_done", linefill_done, 1'b0);
            mq.delete();
            nbeats      = 0;
            prev_done   = 1'b0;
            expect_mreq = 1'b0;
            flush_cnt++;
        end else begin
            if (expect_mreq) check_eq("done_to_mreq", mem_req_vld, 1'b1);
            expect_mreq = 1'b0;
            check_eq("txreq_rdy", txreq_rdy, mq.size() < REQ_DEPTH);
            check_eq("txrsp_is_done", txrsp_vld, linefill_done);
            if (mem_rsp_vld) check_eq("rsp_rdy_mirror", mem_rsp_rdy, rxdat_rdy);
            if (txreq_vld && txreq_rdy) begin
                m.addr   = txreq_pld.addr;
                m.txnid  = txreq_pld.txnid;
                m.opcode = txreq_pld.opcode;
                m.entry  = txreq_entry_id;
                mq.push_back(m);
            end
            if (mem_req_vld) begin
                if (mq.size() == 0) begin
                    check_eq("mreq_unexpected", 1'b1, 1'b0);
                end else begin
                    check_eq("mreq_addr", mem_req_addr, exp_line(mq[0].addr));
                    if (mem_req_rdy) begin
                        addr_log.push_back(mem_req_addr);
                        nbeats = 0;
                        mreq_cnt++;
                    end
                end
            end
            if (rxdat_vld && rxdat_rdy) begin
                if (mq.size() == 0) begin
                    check_eq("beat_unexpected", 1'b1, 1'b0);
                end else begin
                    check_eq("beat_idx", rxdat_beat, exp_beat(mq[0].addr, nbeats));
                    check_eq("beat_entry", rxdat_entry_idx, mq[0].entry);
                    check_eq("beat_txnid", rxdat_txnid, mq[0].txnid);
                    check_eq("beat_data", rxdat_data, mem_rsp_data);
                    beat_log.push_back(int'(rxdat_beat));
                    nbeats++;
                    beat_cnt_seen++;
                    last_beat_cyc = cyc;
                end
            end
            if (linefill_done) begin
                check_eq("done_width", prev_done, 1'b0);
                if (mq.size() == 0) begin
                    check_eq("done_unexpected", 1'b1, 1'b0);
                end else begin
                    check_eq("done_beats", nbeats, BEATS);
                    check_eq("done_latency", cyc - last_beat_cyc, 1);
                    check_eq("ack_idx", linefill_ack_entry_idx, {1'b0, mq[0].entry});
                    check_eq("txrsp_opcode", txrsp_opcode, mq[0].opcode);
                    done_log.push_back(int'(mq[0].entry));
                    void'(mq.pop_front());
                    expect_mreq = (mq.size() > 0);
                    nbeats = 0;
                end
            end
            prev_done = linefill_done;
        end
    end

    // Memory and upstream-sink behaviour, driven just after the rising edge.
    task automatic mem_driver();
        int         left   = 0;
        int         seen_m = 0;
        int         seen_b = 0;
        int         seen_f = 0;
        int         k      = 0;
        logic [3:0] pat    = 4'b1001;
        mem_req_rdy  = 1'b0;
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = '0;
        rxdat_rdy    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (flush_cnt != seen_f) begin
                seen_f      = flush_cnt;
                seen_m      = mreq_cnt;
                seen_b      = beat_cnt_seen;
                left        = 0;
                mem_rsp_vld = 1'b0;
            end
            if (mreq_cnt != seen_m) begin
                seen_m = mreq_cnt;
                left   = BEATS;
            end
            if (beat_cnt_seen != seen_b) begin
                seen_b      = beat_cnt_seen;
                left        = left - 1;
                mem_rsp_vld = 1'b0;
            end
            if (!mem_rsp_vld && left > 0 && (mem_fast || $urandom_range(3) != 0)) begin
                mem_rsp_vld  = 1'b1;
                mem_rsp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            mem_req_rdy = !mem_hold && (mem_fast || $urandom_range(2) != 0);
            case (rx_mode)
                0:       rxdat_rdy = 1'b1;
                1:       rxdat_rdy = ($urandom_range(2) != 0);
                default: begin
                    rxdat_rdy = pat[k % 4];
                    k++;
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [TW-1:0] t, input logic [OW-1:0] o,
                        input logic [EW-1:0] e);
        int n = 0;
        txreq_pld      = '{addr: a, txnid: t, opcode: o};
        txreq_entry_id = e;
        txreq_vld      = 1'b1;
        sample();
        while (!txreq_rdy && n < 2000) begin
            sample();
            n++;
        end
        if (n >= 2000) check_eq("send_timeout", 1'b1, 1'b0);
        step();
        txreq_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        sample();
        while ((mq.size() != 0 || busy) && n < 3000) begin
            sample();
            n++;
        end
        if (n >= 3000) check_eq("idle_timeout", 1'b1, 1'b0);
        step();
    endtask

    initial begin
        int          base_b;
        int          base_d;
        int          base_a;
        int          n;
        int          exp_seq[4];
        int          exp_entries[$];
        logic [31:0] exp_addr0;
        logic [EW-1:0] e;

`ifdef ICACHE_LFR_CRITICAL_WORD_FIRST_EN
        exp_seq   = '{3, 0, 1, 2};
        exp_addr0 = 32'h0000_1230;
`else
        exp_seq   = '{0, 1, 2, 3};
        exp_addr0 = 32'h0000_1200;
`endif
        rst_n          = 1'b1;
        txreq_vld      = 1'b0;
        txreq_pld      = '0;
        txreq_entry_id = '0;
        mem_hold       = 1'b0;
        mem_fast       = 1'b1;
        rx_mode        = 0;
        fork
            mem_driver();
        join_none

        // Reset state
        repeat (3) step();
        sample();
        check_eq("rst_txreq_rdy", txreq_rdy, 1'b0);
        check_eq("rst_mem_req_vld", mem_req_vld, 1'b0);
        check_eq("rst_rxdat_vld", rxdat_vld, 1'b0);
        check_eq("rst_mem_rsp_rdy", mem_rsp_rdy, 1'b0);
        check_eq("rst_txrsp_vld", txrsp_vld, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        step();
        rst_n = 1'b0;
        sample();
        check_eq("post_rst_txreq_rdy", txreq_rdy, 1'b1);
        check_eq("post_rst_busy", busy, 1'b0);
        step();

        // Single miss, no backpressure
        base_b = beat_log.size();
        base_d = done_log.size();
        base_a = addr_log.size();
        send(32'h0000_1234, 4'h5, 3'd1, 2'd2);
        wait_idle();
        check_eq("single_addr", (addr_log.size() > base_a) ? addr_log[base_a] : 32'hDEAD_BEEF, exp_addr0);
        check_eq("single_nbeats", beat_log.size() - base_b, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("single_beat_seq", (beat_log.size() > base_b + i) ? beat_log[base_b + i] : -1, exp_seq[i]);
        end
        check_eq("single_done_entry", (done_log.size() > base_d) ? done_log[base_d] : -1, 2);

        // Fill the queue behind a stalled memory port
        base_d   = done_log.size();
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send($urandom(), TW'($urandom_range(15)), OW'($urandom_range(7)), EW'(i));
        end
        sample();
        check_eq("full_rdy_low", txreq_rdy, 1'b0);
        check_eq("full_busy", busy, 1'b1);
        step();
        mem_hold = 1'b0;
        send($urandom(), TW'($urandom_range(15)), OW'($urandom_range(7)), 2'd0);
        wait_idle();
        exp_entries = '{0, 1, 2, 3, 0};
        check_eq("full_done_count", done_log.size() - base_d, 5);
        for (int i = 0; i < 5; i++) begin
            check_eq("full_done_order", (done_log.size() > base_d + i) ? done_log[base_d + i] : -1, exp_entries[i]);
        end

        // Upstream backpressure pattern
        rx_mode = 2;
        base_b  = beat_log.size();
        send(32'h0000_8A70, 4'h3, 3'd4, 2'd1);
        wait_idle();
        check_eq("bp_nbeats", beat_log.size() - base_b, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_beat_seq", (beat_log.size() > base_b + i) ? beat_log[base_b + i] : -1,
                     exp_beat(32'h0000_8A70, i));
        end

        // Randomized traffic with random stalls on both sides
        mem_fast = 1'b0;
        rx_mode  = 1;
        base_d   = done_log.size();
        exp_entries.delete();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(3)) step();
            e = EW'($urandom_range(3));
            exp_entries.push_back(int'(e));
            send($urandom(), TW'($urandom_range(15)), OW'($urandom_range(7)), e);
        end
        wait_idle();
        check_eq("rand_done_count", done_log.size() - base_d, 40);
        for (int i = 0; i < 40; i++) begin
            check_eq("rand_done_order", (done_log.size() > base_d + i) ? done_log[base_d + i] : -1, exp_entries[i]);
        end

        // Reset in the middle of a line
        mem_fast = 1'b1;
        rx_mode  = 0;
        base_d   = done_log.size();
        send(32'h0000_4440, 4'h9, 3'd2, 2'd3);
        n = 0;
        sample();
        while (nbeats < 2 && n < 500) begin
            sample();
            n++;
        end
        if (n >= 500) check_eq("mid_wait_timeout", 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        sample();
        check_eq("mid_rst_done", linefill_done, 1'b0);
        step();
        rst_n = 1'b0;
        sample();
        check_eq("mid_post_done", linefill_done, 1'b0);
        check_eq("mid_post_mem_req_vld", mem_req_vld, 1'b0);
        check_eq("mid_post_rxdat_vld", rxdat_vld, 1'b0);
        check_eq("mid_post_txrsp_vld", txrsp_vld, 1'b0);
        check_eq("mid_post_busy", busy, 1'b0);
        check_eq("mid_post_txreq_rdy", txreq_rdy, 1'b1);
        check_eq("mid_no_done", done_log.size() - base_d, 0);
        step();
        send(32'h0000_1234, 4'h7, 3'd5, 2'd1);
        wait_idle();
        check_eq("mid_recover_done", done_log.size() - base_d, 1);
        check_eq("mid_recover_entry", (done_log.size() > base_d) ? done_log[base_d] : -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
